// File: rtl/jpeg_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// jpeg_ctrl_pkg
// Shared definitions for the JPEG decode controller: controller state
// encoding, MCU geometry constants and the RGB pixel width.
// ---------------------------------------------------------------------------
package jpeg_ctrl_pkg;

    localparam int unsigned MCU_DIM   = 16;  // MCU edge length in pixels
    localparam int unsigned MCU_SHIFT = 4;   // log2(MCU_DIM)
    localparam int unsigned RGB_W     = 24;  // {r,g,b} pixel width

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StDecode,
        StDone,
        StError
    } ctrl_state_e;

endpackage

// File: rtl/jpeg_pix_addr_gen.sv
// ---------------------------------------------------------------------------
// jpeg_pix_addr_gen
// Two-stage pipeline turning an MCU-ordered decoder pixel into a linear
// frame-buffer write. Stage 1 forms the 17-bit pixel x/y, stage 2 forms
// y*FB_W+x and drops pixels outside the frame buffer or configured image.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_flush                 clears both valid bits (wins over i_vld)
//   i_vld                   pixel valid into stage 1
//   i_adr/i_x_mcu/i_y_mcu   pixel index in MCU, MCU X/Y index
//   i_rgb                   pixel colour
//   i_cfg_width/height      configured image size used for clamping
//   o_vld/o_addr/o_data     registered write strobe, address and data
// ---------------------------------------------------------------------------
module jpeg_pix_addr_gen
    import jpeg_ctrl_pkg::*;
#(
    parameter int unsigned FB_W      = 640,
    parameter int unsigned FB_H      = 480,
    parameter int unsigned FB_ADDR_W = 19
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_flush,
    input  logic                 i_vld,
    input  logic [7:0]           i_adr,
    input  logic [12:0]          i_x_mcu,
    input  logic [12:0]          i_y_mcu,
    input  logic [RGB_W-1:0]     i_rgb,
    input  logic [15:0]          i_cfg_width,
    input  logic [15:0]          i_cfg_height,
    output logic                 o_vld,
    output logic [FB_ADDR_W-1:0] o_addr,
    output logic [RGB_W-1:0]     o_data
);

    logic                 r_s1_vld;
    logic [16:0]          r_s1_x;
    logic [16:0]          r_s1_y;
    logic [RGB_W-1:0]     r_s1_rgb;
    logic                 r_s2_vld;
    logic [FB_ADDR_W-1:0] r_s2_addr;
    logic [RGB_W-1:0]     r_s2_data;

    logic                 w_in_range;
    logic [FB_ADDR_W-1:0] w_lin_addr;

    always_comb begin
        w_in_range = (r_s1_x < 17'(FB_W)) && (r_s1_y < 17'(FB_H)) &&
                     (r_s1_x < {1'b0, i_cfg_width}) && (r_s1_y < {1'b0, i_cfg_height});
        // Truncation is harmless: out-of-range coordinates never produce a write.
        w_lin_addr = FB_ADDR_W'(r_s1_y) * FB_ADDR_W'(FB_W) + FB_ADDR_W'(r_s1_x);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_x    <= '0;
            r_s1_y    <= '0;
            r_s1_rgb  <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_addr <= '0;
            r_s2_data <= '0;
        end else begin
            if (i_vld) begin
                // x = x_mcu*16 + adr[3:0], y = y_mcu*16 + adr[7:4]
                r_s1_x   <= {i_x_mcu, i_adr[MCU_SHIFT-1:0]};
                r_s1_y   <= {i_y_mcu, i_adr[7:MCU_SHIFT]};
                r_s1_rgb <= i_rgb;
            end
            if (r_s1_vld && w_in_range) begin
                r_s2_addr <= w_lin_addr;
                r_s2_data <= r_s1_rgb;
            end
            if (i_flush) begin
                r_s1_vld <= 1'b0;
                r_s2_vld <= 1'b0;
            end else begin
                r_s1_vld <= i_vld;
                r_s2_vld <= r_s1_vld && w_in_range;
            end
        end
    end

    assign o_vld  = r_s2_vld;
    assign o_addr = r_s2_addr;
    assign o_data = r_s2_data;

endmodule

// File: rtl/jpeg_decode_ctrl.sv
// ---------------------------------------------------------------------------
// jpeg_decode_ctrl
// Sequences one JPEG decode into the frame buffer: optional background clear,
// decoder enable, MCU-to-linear pixel writes, end-of-image detection, a
// no-pixel watchdog, abort and restart.
// Optional feature macro: JPEG_CTRL_CLEAR_EN (enables the CLEAR state).
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_start, i_abort         begin decode / cancel current operation
//   i_cfg_*                  decoder configuration (image and MCU counts)
//   i_pix_*                  decoder pixel stream
//   o_dec_we, o_dec_rst      decoder input enable and soft reset
//   o_fb_wr_*                frame-buffer write port
//   o_busy/o_done/o_error    status (CLEAR|DECODE / DONE / ERROR)
//   o_pix_count              committed pixel writes, saturating
// ---------------------------------------------------------------------------
module jpeg_decode_ctrl
    import jpeg_ctrl_pkg::*;
#(
    parameter int unsigned       FB_W           = 640,
    parameter int unsigned       FB_H           = 480,
    parameter int unsigned       FB_ADDR_W      = 19,
    parameter logic [RGB_W-1:0]  BG_COLOR       = 24'h000000,
    parameter int unsigned       TIMEOUT_CYCLES = 1048576
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic                 i_cfg_en,
    input  logic [15:0]          i_cfg_width,
    input  logic [15:0]          i_cfg_height,
    input  logic [12:0]          i_cfg_mcu_w,
    input  logic [12:0]          i_cfg_mcu_h,
    input  logic                 i_pix_we,
    input  logic                 i_pix_end,
    input  logic [7:0]           i_pix_adr,
    input  logic [12:0]          i_pix_x_mcu,
    input  logic [12:0]          i_pix_y_mcu,
    input  logic [RGB_W-1:0]     i_pix_rgb,
    output logic                 o_dec_we,
    output logic                 o_dec_rst,
    output logic                 o_fb_wr_en,
    output logic [FB_ADDR_W-1:0] o_fb_wr_addr,
    output logic [RGB_W-1:0]     o_fb_wr_data,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error,
    output logic [FB_ADDR_W-1:0] o_pix_count
);

    localparam int unsigned FB_PIX = FB_W * FB_H;
    localparam int unsigned WD_W   = $clog2(TIMEOUT_CYCLES + 1);

`ifdef JPEG_CTRL_CLEAR_EN
    localparam ctrl_state_e ST_START = StClear;
`else
    localparam ctrl_state_e ST_START = StDecode;
`endif

    ctrl_state_e          r_state, w_state_d;
    logic [FB_ADDR_W-1:0] r_clr_cnt, w_clr_cnt_d;
    logic [WD_W-1:0]      r_wdog, w_wdog_d;
    logic [FB_ADDR_W-1:0] r_pix_count;
    logic                 r_dec_we, r_dec_rst, r_busy, r_done, r_error;
    logic                 w_start_acc, w_eoi, w_wdog_exp, w_clr_last, w_flush;
    logic                 w_pipe_vld;
    logic [FB_ADDR_W-1:0] w_pipe_addr;
    logic [RGB_W-1:0]     w_pipe_data;

    assign w_eoi = i_pix_we && i_pix_end && i_cfg_en &&
                   (i_pix_x_mcu == i_cfg_mcu_w - 13'd1) &&
                   (i_pix_y_mcu == i_cfg_mcu_h - 13'd1);
    assign w_wdog_exp = (r_wdog == WD_W'(TIMEOUT_CYCLES - 1)) && !i_pix_we;
    assign w_clr_last = (r_clr_cnt == FB_ADDR_W'(FB_PIX - 1));

    always_comb begin
        w_state_d   = r_state;
        w_clr_cnt_d = r_clr_cnt;
        w_wdog_d    = r_wdog;
        w_start_acc = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_d   = ST_START;
                    w_start_acc = 1'b1;
                end
            end
            StClear: begin
                if (i_abort)         w_state_d = StIdle;
                else if (w_clr_last) w_state_d = StDecode;
                else                 w_clr_cnt_d = r_clr_cnt + FB_ADDR_W'(1);
            end
            StDecode: begin
                // abort > end-of-image > watchdog
                if (i_abort)         w_state_d = StIdle;
                else if (w_eoi)      w_state_d = StDone;
                else if (w_wdog_exp) w_state_d = StError;
                else                 w_wdog_d  = i_pix_we ? '0 : r_wdog + WD_W'(1);
            end
            StDone, StError: begin
                if (i_abort) begin
                    w_state_d = StIdle;
                end else if (i_start) begin
                    w_state_d   = ST_START;
                    w_start_acc = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
        if (w_start_acc) w_clr_cnt_d = '0;
        if (w_state_d == StDecode && r_state != StDecode) w_wdog_d = '0;
    end

    // Leaving to IDLE or ERROR discards anything in flight; DONE lets it drain.
    assign w_flush = (w_state_d == StIdle) || (w_state_d == StError);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_clr_cnt   <= '0;
            r_wdog      <= '0;
            r_pix_count <= '0;
            r_dec_we    <= 1'b0;
            r_dec_rst   <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_clr_cnt <= w_clr_cnt_d;
            r_wdog    <= w_wdog_d;
            r_dec_we  <= (w_state_d == StDecode);
            r_dec_rst <= (w_state_d != StDecode);
            r_busy    <= (w_state_d == StClear) || (w_state_d == StDecode);
            r_done    <= (w_state_d == StDone);
            r_error   <= (w_state_d == StError);
            if (w_start_acc)                    r_pix_count <= '0;
            else if (w_pipe_vld && !(&r_pix_count)) r_pix_count <= r_pix_count + FB_ADDR_W'(1);
        end
    end

    jpeg_pix_addr_gen #(
        .FB_W      (FB_W),
        .FB_H      (FB_H),
        .FB_ADDR_W (FB_ADDR_W)
    ) u_addr_gen (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_flush      (w_flush),
        .i_vld        (i_pix_we && (r_state == StDecode)),
        .i_adr        (i_pix_adr),
        .i_x_mcu      (i_pix_x_mcu),
        .i_y_mcu      (i_pix_y_mcu),
        .i_rgb        (i_pix_rgb),
        .i_cfg_width  (i_cfg_width),
        .i_cfg_height (i_cfg_height),
        .o_vld        (w_pipe_vld),
        .o_addr       (w_pipe_addr),
        .o_data       (w_pipe_data)
    );

    // Clear writes come straight from registered state; they take priority over
    // a drained pixel if a restart lands on the drain cycle.
    always_comb begin
        if (r_state == StClear) begin
            o_fb_wr_en   = 1'b1;
            o_fb_wr_addr = r_clr_cnt;
            o_fb_wr_data = BG_COLOR;
        end else begin
            o_fb_wr_en   = w_pipe_vld;
            o_fb_wr_addr = w_pipe_addr;
            o_fb_wr_data = w_pipe_data;
        end
    end

    assign o_dec_we    = r_dec_we;
    assign o_dec_rst   = r_dec_rst;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_error     = r_error;
    assign o_pix_count = r_pix_count;

endmodule

// File: doc/jpeg_decode_ctrl.md
Name: jpeg_decode_ctrl

Overview:
Sequences one JPEG decode into the frame buffer: optionally clears the buffer to a background colour, then enables the decoder input and converts MCU-ordered pixels into linear frame-buffer writes. It detects end-of-image, detects a stalled decoder with a watchdog, and supports abort and restart. It sits between the top-level start logic, jpeg_top (input enable and pixel/config outputs) and the frame_buffer write port.

Parameters:
FB_W, 640, frame-buffer width in pixels
FB_H, 480, frame-buffer height in pixels
FB_ADDR_W, 19, frame-buffer address width; must satisfy 2^FB_ADDR_W >= FB_W*FB_H
BG_COLOR, 24'h000000, RGB fill value written during CLEAR
TIMEOUT_CYCLES, 1048576, DECODE cycles allowed without a pixel before ERROR

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
start  in  1  begin decode; sampled only in IDLE, DONE or ERROR
abort  in  1  cancel current operation
cfg_en  in  1  decoder configuration valid (level)
cfg_width  in  16  image width in pixels
cfg_height  in  16  image height in pixels
cfg_mcu_w  in  13  MCU count in X
cfg_mcu_h  in  13  MCU count in Y
pix_we  in  1  decoder pixel valid
pix_end  in  1  last pixel of the current MCU
pix_adr  in  8  pixel index within a 16x16 MCU
pix_x_mcu  in  13  MCU X index
pix_y_mcu  in  13  MCU Y index
pix_rgb  in  24  pixel colour {r,g,b}
dec_we  out  1  decoder input enable (drives ai_we and gates ROM reads)
dec_rst  out  1  decoder soft reset
fb_wr_en  out  1  frame-buffer write strobe
fb_wr_addr  out  FB_ADDR_W  frame-buffer write address
fb_wr_data  out  24  frame-buffer write data
busy  out  1  high in CLEAR or DECODE
done  out  1  high in DONE
error  out  1  high in ERROR
pix_count  out  FB_ADDR_W  frame-buffer writes committed in DECODE, saturating

Behaviour:
- Reset values: state IDLE; dec_we, fb_wr_en, busy, done and error are 0; fb_wr_addr, fb_wr_data and pix_count are 0; dec_rst is 1 (held in IDLE).
- State outputs are registered from the next state. All outputs change on clk edges only.
- IDLE: dec_rst=1. On start, go to CLEAR and reset the clear counter to 0.
- CLEAR:
  - dec_rst=1.
  - One write per cycle: addr = counter, data = BG_COLOR.
  - When counter reaches FB_W*FB_H-1, that final write is issued and the state moves to DECODE.
  - Total duration is exactly FB_W*FB_H cycles.
- DECODE:
  - dec_rst=0 and dec_we=1.
  - The pixel path is a 2-stage registered pipeline; latency from pix_we to fb_wr_en is 2 cycles.
  - Stage 1 computes x = pix_x_mcu*16 + pix_adr[3:0] and y = pix_y_mcu*16 + pix_adr[7:4], both 17 bits with no truncation.
  - Stage 2 computes addr = y*FB_W + x.
  - The write is suppressed if x >= FB_W, y >= FB_H, x >= cfg_width or y >= cfg_height. The pipeline still advances when a write is suppressed.
  - pix_count increments per committed write and saturates at all-ones.
- DECODE exit to DONE:
  - Condition: pix_we & pix_end & cfg_en & pix_x_mcu==cfg_mcu_w-1 & pix_y_mcu==cfg_mcu_h-1.
  - dec_we drops the cycle after the condition.
  - The pipeline drains, so the final pixel's write is still issued in DONE.
- Watchdog: a counter clears on every pix_we and on DECODE entry. If it reaches TIMEOUT_CYCLES, go to ERROR; dec_we drops and the pipeline is flushed with no writes.
- DONE and ERROR: dec_rst=1. start returns to CLEAR and clears pix_count.
- abort: in CLEAR, DECODE, DONE or ERROR, go to IDLE next cycle. Pipeline valid bits are cleared, so no fb_wr_en occurs from the next cycle onward.
- Simultaneous events: abort beats start. The end-of-image condition beats the watchdog expiring in the same cycle. start is ignored while busy.
- cfg_en low during DECODE: writes are not gated on it, but end-of-image cannot be detected.

Optional Feature:
Macro JPEG_CTRL_CLEAR_EN.
- Defined: CLEAR state exists as described.
- Undefined: start goes IDLE -> DECODE directly, BG_COLOR is unused, and the first DECODE cycle has dec_rst=0.

Decomposition:
- Package jpeg_ctrl_pkg:
  - state encoding (IDLE, CLEAR, DECODE, DONE, ERROR)
  - MCU_DIM=16 and MCU_SHIFT=4
  - the RGB width constant 24
- Sub-module jpeg_pix_addr_gen: the 2-stage MCU-to-linear address pipeline with clamp, valid-in/valid-out and a flush input. The controller FSM, watchdog and clear counter stay in jpeg_decode_ctrl.

Test Plan:
- FB_W=32, FB_H=16, CLEAR_EN defined; pulse start -> exactly 512 writes of BG_COLOR at addresses 0..511 on consecutive cycles, then dec_we=1.
- cfg 32x16, mcu 2x1; pix_x_mcu=1, pix_adr=8'h23 -> 2 cycles later fb_wr_addr = 2*32+19 = 83, with data equal to pix_rgb.
- cfg_width=20; pixel with x=25 -> no fb_wr_en, pix_count unchanged; pixel with x=19 -> write committed.
- Last MCU (1,0) with pix_end -> done=1 the next cycle, dec_we=0, final write issued 2 cycles after the pixel.
- TIMEOUT_CYCLES=64, no pix_we in DECODE -> error=1 on cycle 64 and no further writes; then start -> CLEAR restarts and pix_count=0.
- abort asserted mid-DECODE with 2 pixels in flight -> IDLE next cycle, zero subsequent fb_wr_en, dec_rst=1.
